// File: rtl/dcache_write_port.sv
// Direct-mapped, write-back, write-allocate data cache that answers store-buffer
// drains and loads. A miss stalls the requester, evicts a dirty victim, fills
// the line from memory and then replays the original access.
module dcache_write_port #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sb_write,
    input  logic [31:0]              sb_addr,
    input  logic [31:0]              sb_data,
    input  logic                     sb_byte,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    input  logic                     ld_byte,
    output logic [31:0]              ld_data,
    output logic                     ld_valid,
    output logic                     busy,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [LINE_WORDS*32-1:0] mem_wdata,
    input  logic [LINE_WORDS*32-1:0] mem_rdata,
    input  logic                     mem_ready
);
    localparam int LINE_W = LINE_WORDS * 32;
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } req_t;

    typedef logic [LINE_WORDS-1:0][3:0][7:0] line_t;

    state_t             st, nxt;
    req_t               req, lat;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [LINE_W-1:0]  data_q [NUM_LINES];

    logic [IDX_W-1:0]   req_idx, lat_idx, arr_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic               hit;
    logic               arr_we, install, mark_dirty, latch, ld_fire;
    logic [LINE_W-1:0]  arr_line;
    logic [31:0]        ld_word;

    // Store merge: a word store replaces the selected word, a byte store one lane.
    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line, input req_t r);
        line_t             l;
        logic [WSEL_W-1:0] w;
        l = line;
        w = r.addr[OFF_W-1:2];
        if (r.is_byte) l[w][r.addr[1:0]] = r.data[7:0];
        else           l[w] = r.data;
        return l;
    endfunction

    // Load extract: word, or a zero-extended byte lane.
    function automatic logic [31:0] extract(input logic [LINE_W-1:0] line, input req_t r);
        line_t             l;
        logic [WSEL_W-1:0] w;
        l = line;
        w = r.addr[OFF_W-1:2];
        if (r.is_byte) return {24'b0, l[w][r.addr[1:0]]};
        return l[w];
    endfunction

    // Incoming request (drain write wins) and its tag lookup.
    always_comb begin
        req.wr      = sb_write;
        req.addr    = sb_write ? sb_addr : ld_addr;
        req.data    = sb_data;
        req.is_byte = sb_write ? sb_byte : ld_byte;
        req_idx     = req.addr[OFF_W +: IDX_W];
        req_tag     = req.addr[31 -: TAG_W];
        lat_idx     = lat.addr[OFF_W +: IDX_W];
        lat_tag     = lat.addr[31 -: TAG_W];
        hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    end

    // Next-state logic, array write controls and memory-side outputs.
    always_comb begin
        nxt        = st;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arr_we     = 1'b0;
        arr_idx    = lat_idx;
        arr_line   = '0;
        install    = 1'b0;
        mark_dirty = 1'b0;
        latch      = 1'b0;
        ld_fire    = 1'b0;
        ld_word    = '0;
        case (st)
            IDLE: begin
                if (sb_write || ld_req) begin
                    if (hit) begin
                        arr_idx = req_idx;
                        if (req.wr) begin
                            arr_we     = 1'b1;
                            arr_line   = merge(data_q[req_idx], req);
                            mark_dirty = 1'b1;
                        end else begin
                            ld_fire = 1'b1;
                            ld_word = extract(data_q[req_idx], req);
                        end
                    end else begin
                        latch = 1'b1;
                        nxt   = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[lat_idx], lat_idx, {OFF_W{1'b0}}};
                mem_wdata = data_q[lat_idx];
                if (mem_ready) nxt = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    arr_we   = 1'b1;
                    arr_line = mem_rdata;
                    install  = 1'b1;
                    nxt      = RESPOND;
                end
            end
            RESPOND: begin
                // Replay the stalled access against the freshly filled line.
                if (lat.wr) begin
                    arr_we     = 1'b1;
                    arr_line   = merge(data_q[lat_idx], lat);
                    mark_dirty = 1'b1;
                end else begin
                    ld_fire = 1'b1;
                    ld_word = extract(data_q[lat_idx], lat);
                end
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign busy = (st != IDLE);

    // Control state: FSM, line status bits, latched request, load response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            lat      <= '0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
        end else begin
            st       <= nxt;
            ld_valid <= ld_fire;
            if (ld_fire) ld_data <= ld_word;
            if (latch)   lat     <= req;
            if (install) begin
                valid_q[arr_idx] <= 1'b1;
                dirty_q[arr_idx] <= 1'b0;
            end
            if (mark_dirty) dirty_q[arr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are qualified by valid so need no reset.
    always_ff @(posedge clk) begin
        if (arr_we)  data_q[arr_idx] <= arr_line;
        if (install) tag_q[arr_idx]  <= lat_tag;
    end
endmodule

// File: tb/tb_dcache_write_port.sv
// Directed bench for dcache_write_port with a small wait-state memory model.
module tb_dcache_write_port;
    logic         clk, rst;
    logic         sb_write, sb_byte, ld_req, ld_byte;
    logic [31:0]  sb_addr, sb_data, ld_addr;
    logic [31:0]  ld_data;
    logic         ld_valid, busy, mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // memory model state
    int           waits = 0;
    int           wcnt  = 0;
    int           n_fill = 0, n_wb = 0, fill_cyc = 0;
    logic [31:0]  last_fill_addr = '0, last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    logic [127:0] fill_line = '0;

    dcache_write_port dut (
        .clk(clk), .rst(rst),
        .sb_write(sb_write), .sb_addr(sb_addr), .sb_data(sb_data), .sb_byte(sb_byte),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .ld_data(ld_data), .ld_valid(ld_valid), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = fill_line;

    // Memory ready after 'waits' extra cycles of mem_req.
    always @(negedge clk) begin
        if (mem_req) begin
            if (!mem_we) fill_cyc++;
            mem_ready = (wcnt == waits);
            wcnt = (wcnt == waits) ? 0 : wcnt + 1;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Log completed memory transactions.
    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                n_wb++;
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
            end else begin
                n_fill++;
                last_fill_addr = mem_addr;
            end
        end
    end

    // Present one request and run until the block is idle again.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit byt, output int bcyc, output bit vld,
                          output logic [31:0] rdata, output bit ok);
        @(negedge clk);
        if (wr) begin
            sb_write = 1; sb_addr = addr; sb_data = data; sb_byte = byt;
        end else begin
            ld_req = 1; ld_addr = addr; ld_byte = byt;
        end
        bcyc = 0; vld = 0; rdata = '0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sb_write = 0;
            if (busy) bcyc++;
            else begin
                ok = 1; vld = ld_valid; rdata = ld_data; ld_req = 0;
                break;
            end
        end
        ld_req = 0;
    endtask

    task automatic test_reset();
        rst = 0; sb_write = 0; sb_addr = '0; sb_data = '0; sb_byte = 0;
        ld_req = 0; ld_addr = '0; ld_byte = 0; mem_ready = 0;
        #2 rst = 1;
        #2;
        checks++; if (ld_data !== 32'h0)   begin errors++; $display("FAIL rst_ld_data got %h exp 0", ld_data); end
        checks++; if (ld_valid !== 1'b0)   begin errors++; $display("FAIL rst_ld_valid got %b exp 0", ld_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0)  begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 128'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_load_miss();
        int bc; bit v, ok; logic [31:0] d; int f0;
        waits = 2;
        fill_line = {32'h44444444, 32'h33333333, 32'h55556666, 32'h11112222};
        f0 = n_fill;
        do_req(0, 32'h40, '0, 0, bc, v, d, ok);
        checks++; if (!ok)       begin errors++; $display("FAIL miss_timeout busy never fell"); end
        checks++; if (bc != 4)   begin errors++; $display("FAIL miss_busy_cycles got %0d exp 4", bc); end
        checks++; if (n_fill - f0 != 1) begin errors++; $display("FAIL miss_fill_count got %0d exp 1", n_fill - f0); end
        checks++; if (last_fill_addr !== 32'h40) begin errors++; $display("FAIL miss_fill_addr got %h exp 40", last_fill_addr); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL miss_ld_valid got %b exp 1", v); end
        checks++; if (d !== 32'h11112222) begin errors++; $display("FAIL miss_ld_data got %h exp 11112222", d); end
        @(negedge clk);
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL miss_valid_pulse got %b exp 0", ld_valid); end
    endtask

    task automatic test_byte_rw();
        int bc; bit v, ok; logic [31:0] d; int m0;
        m0 = n_fill + n_wb;
        do_req(1, 32'h42, 32'h000055AB, 1, bc, v, d, ok);
        checks++; if (!ok || bc != 0) begin errors++; $display("FAIL bstore_busy got %0d exp 0", bc); end
        do_req(0, 32'h42, '0, 1, bc, v, d, ok);
        checks++; if (!ok || bc != 0 || v !== 1'b1) begin errors++; $display("FAIL bload_latency busy %0d valid %b exp 0/1", bc, v); end
        checks++; if (d !== 32'h000000AB) begin errors++; $display("FAIL bload_data got %h exp 000000ab", d); end
        do_req(0, 32'h40, '0, 0, bc, v, d, ok);
        checks++; if (d !== 32'h11AB2222 || v !== 1'b1) begin errors++; $display("FAIL word_after_bstore got %h exp 11ab2222", d); end
        checks++; if (n_fill + n_wb != m0) begin errors++; $display("FAIL hit_no_mem got %0d exp %0d", n_fill + n_wb, m0); end
    endtask

    task automatic test_writeback();
        int bc; bit v, ok; logic [31:0] d; int w0, f0;
        waits = 1;
        fill_line = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        w0 = n_wb; f0 = n_fill;
        do_req(1, 32'h140, 32'hDEADBEEF, 0, bc, v, d, ok);
        checks++; if (!ok || bc != 5) begin errors++; $display("FAIL wb_busy_cycles got %0d exp 5", bc); end
        checks++; if (n_wb - w0 != 1) begin errors++; $display("FAIL wb_count got %0d exp 1", n_wb - w0); end
        checks++; if (last_wb_addr !== 32'h40) begin errors++; $display("FAIL wb_addr got %h exp 40", last_wb_addr); end
        checks++; if (last_wb_data !== {32'h44444444, 32'h33333333, 32'h55556666, 32'h11AB2222})
            begin errors++; $display("FAIL wb_data got %h", last_wb_data); end
        checks++; if (n_fill - f0 != 1 || last_fill_addr !== 32'h140)
            begin errors++; $display("FAIL wb_fill got %0d @%h exp 1 @140", n_fill - f0, last_fill_addr); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL wb_store_no_valid got %b exp 0", v); end
        do_req(0, 32'h140, '0, 0, bc, v, d, ok);
        checks++; if (bc != 0 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_store_data got %h busy %0d exp deadbeef/0", d, bc); end
        do_req(0, 32'h147, '0, 1, bc, v, d, ok);
        checks++; if (d !== 32'h000000A1) begin errors++; $display("FAIL wb_fill_byte got %h exp 000000a1", d); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sb_write = 1; sb_addr = 32'h148; sb_data = 32'hCAFEF00D; sb_byte = 0;
        ld_req = 1; ld_addr = 32'h148; ld_byte = 0;
        @(negedge clk);
        sb_write = 0;
        checks++; if (ld_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first got valid %b busy %b exp 0/0", ld_valid, busy); end
        @(negedge clk);
        ld_req = 0;
        checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", ld_valid); end
        checks++; if (ld_data !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data got %h exp cafef00d", ld_data); end
    endtask

    task automatic test_dirty_evict();
        int bc; bit v, ok; logic [31:0] d;
        waits = 0;
        fill_line = {32'h0, 32'h0, 32'h0, 32'h77778888};
        do_req(0, 32'h40, '0, 0, bc, v, d, ok);
        checks++; if (!ok || bc != 3) begin errors++; $display("FAIL evict_busy got %0d exp 3", bc); end
        checks++; if (last_wb_addr !== 32'h140) begin errors++; $display("FAIL evict_addr got %h exp 140", last_wb_addr); end
        checks++; if (last_wb_data !== {32'hA3A3A3A3, 32'hCAFEF00D, 32'hA1A1A1A1, 32'hDEADBEEF})
            begin errors++; $display("FAIL evict_data got %h", last_wb_data); end
        checks++; if (d !== 32'h77778888 || v !== 1'b1) begin errors++; $display("FAIL evict_ld got %h exp 77778888", d); end
    endtask

    task automatic test_zero_wait();
        int bc; bit v, ok; logic [31:0] d; int f0, c0;
        waits = 0;
        fill_line = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h94949494, 32'h0A0A0A0A};
        f0 = n_fill; c0 = fill_cyc;
        do_req(0, 32'h94, '0, 0, bc, v, d, ok);
        checks++; if (!ok || bc != 2) begin errors++; $display("FAIL zw_busy got %0d exp 2", bc); end
        checks++; if (fill_cyc - c0 != 1) begin errors++; $display("FAIL zw_fill_cycles got %0d exp 1", fill_cyc - c0); end
        checks++; if (n_fill - f0 != 1 || last_fill_addr !== 32'h90)
            begin errors++; $display("FAIL zw_fill got %0d @%h exp 1 @90", n_fill - f0, last_fill_addr); end
        checks++; if (d !== 32'h94949494) begin errors++; $display("FAIL zw_data got %h exp 94949494", d); end
    endtask

    task automatic test_rst_mid();
        int bc; bit v, ok; logic [31:0] d; int f0;
        waits = 5;
        fill_line = {32'h0, 32'h0, 32'h0, 32'h5A5A0A0A};
        @(negedge clk);
        ld_req = 1; ld_addr = 32'hA0; ld_byte = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_in_fill got req %b we %b exp 1/0", mem_req, mem_we); end
        rst = 1; ld_req = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_mem_req got %b exp 0", mem_req); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        #2 rst = 0;
        waits = 0;
        f0 = n_fill;
        do_req(0, 32'hA0, '0, 0, bc, v, d, ok);
        checks++; if (!ok || bc != 2 || n_fill - f0 != 1)
            begin errors++; $display("FAIL rmid_remiss got busy %0d fills %0d exp 2/1", bc, n_fill - f0); end
        checks++; if (d !== 32'h5A5A0A0A) begin errors++; $display("FAIL rmid_data got %h exp 5a5a0a0a", d); end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_byte_rw();
        test_writeback();
        test_back_to_back();
        test_dirty_evict();
        test_zero_wait();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
